input_router_vc: RTL



---
 rtl/input_router_vc.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/input_router_vc.sv
// Registered input-port router with per-VC route table and dimension-ordered routing.
// Head flits compute a one-hot port; body/tail flits reuse the route stored for their VC.
module input_router_vc #(
   parameter int unsigned NUM_VC      = 3,
   parameter int unsigned X_WIDTH     = 2,
   parameter int unsigned Y_WIDTH     = 2,
   parameter int unsigned FLIT_WIDTH  = 34,
   parameter int unsigned ROUTING_ALG = 0,
   parameter int unsigned ERR_CNT_W   = 8,
   localparam int unsigned VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [X_WIDTH-1:0]    router_x_i,
   input  logic [Y_WIDTH-1:0]    router_y_i,
   input  logic                  flit_valid_i,
   output logic                  flit_ready_o,
   input  logic [FLIT_WIDTH-1:0] flit_i,
   input  logic [VC_W-1:0]       vc_id_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [FLIT_WIDTH-1:0] out_flit_o,
   output logic [VC_W-1:0]       out_vc_o,
   output logic [4:0]            out_port_o,
   output logic                  err_o,
   output logic [ERR_CNT_W-1:0]  err_cnt_o
);

   typedef enum logic [1:0] {
      FtHead     = 2'b00,
      FtBody     = 2'b01,
      FtTail     = 2'b10,
      FtHeadTail = 2'b11
   } flit_type_e;

   localparam logic [4:0] PortN = 5'b00001;
   localparam logic [4:0] PortS = 5'b00010;
   localparam logic [4:0] PortW = 5'b00100;
   localparam logic [4:0] PortE = 5'b01000;
   localparam logic [4:0] PortL = 5'b10000;

   function automatic logic [4:0] calc_route(input logic [X_WIDTH-1:0] dx,
                                             input logic [Y_WIDTH-1:0] dy,
                                             input logic [X_WIDTH-1:0] rx,
                                             input logic [Y_WIDTH-1:0] ry);
      logic [4:0] x_port;
      logic [4:0] y_port;
      x_port = (dx > rx) ? PortE : (dx < rx) ? PortW : 5'b0;
      y_port = (dy > ry) ? PortS : (dy < ry) ? PortN : 5'b0;
      if (ROUTING_ALG == 0) begin
         calc_route = (x_port != 5'b0) ? x_port : (y_port != 5'b0) ? y_port : PortL;
      end else begin
         calc_route = (y_port != 5'b0) ? y_port : (x_port != 5'b0) ? x_port : PortL;
      end
   endfunction

   logic                  out_valid_q;
   logic [FLIT_WIDTH-1:0] out_flit_q;
   logic [VC_W-1:0]       out_vc_q;
   logic [4:0]            out_port_q;
   logic                  err_q;
   logic [ERR_CNT_W-1:0]  err_cnt_q;
   logic [NUM_VC-1:0]     vc_active_q;
   logic [4:0]            route_q [NUM_VC];

   flit_type_e            ftype;
   logic [X_WIDTH-1:0]    dest_x;
   logic [Y_WIDTH-1:0]    dest_y;
   logic                  accept;
   logic                  is_head;
   logic                  vc_ok;
   logic [VC_W-1:0]       vc_idx;
   logic                  cur_active;
   logic [4:0]            cur_route;
   logic [4:0]            new_route;
   logic [4:0]            fwd_route;
   logic                  fwd;
   logic                  err_ev;
   logic                  next_active;

   assign flit_ready_o = arst && (!out_valid_q || out_ready_i);
   assign out_valid_o  = out_valid_q;
   assign out_flit_o   = out_flit_q;
   assign out_vc_o     = out_vc_q;
   assign out_port_o   = out_port_q;
   assign err_o        = err_q;
   assign err_cnt_o    = err_cnt_q;

   always_comb begin
      ftype      = flit_type_e'(flit_i[FLIT_WIDTH-1 -: 2]);
      dest_x     = flit_i[FLIT_WIDTH-3 -: X_WIDTH];
      dest_y     = flit_i[FLIT_WIDTH-3-X_WIDTH -: Y_WIDTH];
      accept     = flit_valid_i && flit_ready_o;
      is_head    = (ftype == FtHead) || (ftype == FtHeadTail);
      vc_ok      = 32'(vc_id_i) < NUM_VC;
      // Clamp so out-of-range VC ids never address the tables.
      vc_idx     = vc_ok ? vc_id_i : '0;
      cur_active = vc_active_q[vc_idx];
      cur_route  = route_q[vc_idx];
      new_route  = calc_route(dest_x, dest_y, router_x_i, router_y_i);
      fwd_route  = is_head ? new_route : cur_route;
      fwd        = accept && vc_ok && (is_head || cur_active);
      err_ev     = accept && (!vc_ok || ((ftype == FtHead) && cur_active) ||
                              (!is_head && !cur_active));
      next_active = cur_active;
      unique case (ftype)
         FtHead:     next_active = 1'b1;
         FtHeadTail: next_active = 1'b0;
         FtTail:     next_active = 1'b0;
         FtBody:     next_active = cur_active;
         default:    next_active = cur_active;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arst) begin
         out_valid_q <= 1'b0;
         out_flit_q  <= '0;
         out_vc_q    <= '0;
         out_port_q  <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         vc_active_q <= '0;
         for (int i = 0; i < int'(NUM_VC); i++) begin
            route_q[i] <= '0;
         end
      end else begin
         if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
         if (fwd) begin
            out_valid_q <= 1'b1;
            out_flit_q  <= flit_i;
            out_vc_q    <= vc_id_i;
            out_port_q  <= fwd_route;
         end
         err_q <= err_ev;
         if (err_ev && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
         end
         if (accept && vc_ok) begin
            vc_active_q[vc_idx] <= next_active;
            if (is_head) begin
               route_q[vc_idx] <= new_route;
            end
         end
      end
   end

endmodule
